// File: rtl/decoder3x8_pipe_pkg.sv
// Shared definitions for the pipelined 3-to-8 decoder: FSM encoding,
// decoder widths, FIFO depth and the one-hot helper.
package decoder3x8_pipe_pkg;

    localparam int N_OUT      = 8;
    localparam int CODE_W     = 3;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        PASS  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    function automatic logic [N_OUT-1:0] oneHot(input logic [CODE_W-1:0] code);
        logic [N_OUT-1:0] word;
        word       = '0;
        word[code] = 1'b1;
        return word;
    endfunction

endpackage

// File: rtl/decoder3x8_pipe_sync_fifo2.sv
// Two-entry synchronous FIFO; pushes while full and pops while empty are
// ignored, so callers may gate them loosely.
module sync_fifo2
    import decoder3x8_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic         wrPtr_q;
    logic         rdPtr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         doPush;
    logic         doPop;

    assign full   = (count_q == 2'(FIFO_DEPTH));
    assign empty  = (count_q == 2'd0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign dout   = mem_q[rdPtr_q];

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 2'd1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= din;
                wrPtr_q        <= ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/decoder3x8_pipe.sv
// Pipelined 3-to-8 decoder with a 2-entry output FIFO, a self-test sweep
// generator (PASS/SWEEP FSM) and a wrapping output-transfer counter.
module decoder3x8_pipe
    import decoder3x8_pipe_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sweep_start,
    output logic [7:0]       out,
    output logic [2:0]       out_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int DW = CODE_W + N_OUT;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  genCode_q, genCode_d;
    logic [CNT_W-1:0]   xferCount_q, xferCount_d;

    logic               fifoFull;
    logic               fifoEmpty;
    logic               inXfer;
    logic               genPush;
    logic               push;
    logic               pop;
    logic [CODE_W-1:0]  pushCode;
    logic [DW-1:0]      pushData;
    logic [DW-1:0]      headData;

    assign in_ready = (state_q == PASS) && !fifoFull;
    assign busy     = (state_q == SWEEP);
    assign inXfer   = in_valid && in_ready;
    assign genPush  = (state_q == SWEEP) && !fifoFull;
    assign push     = inXfer || genPush;
    assign pushCode = genPush ? genCode_q : in_code;
    assign pushData = {pushCode, oneHot(pushCode)};

    // The FIFO array keeps its last contents after a pop, so the outputs are
    // masked to present zeros whenever nothing is queued.
    assign out_valid  = !fifoEmpty;
    assign pop        = out_valid && out_ready;
    assign out        = fifoEmpty ? '0 : headData[N_OUT-1:0];
    assign out_code   = fifoEmpty ? '0 : headData[DW-1:N_OUT];
    assign xfer_count = xferCount_q;

    sync_fifo2 #(
        .W (DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pushData),
        .dout  (headData),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    // The generator counter wraps 7->0 on its own, so leaving SWEEP needs no
    // explicit clear of the sweep code.
    always_comb begin
        state_d     = state_q;
        genCode_d   = genCode_q;
        xferCount_d = xferCount_q;
        case (state_q)
            PASS: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (genPush) begin
                    genCode_d = genCode_q + 3'd1;
                    if (genCode_q == 3'(N_OUT - 1)) begin
                        state_d = PASS;
                    end
                end
            end
            default: state_d = PASS;
        endcase
        if (pop) begin
            xferCount_d = xferCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PASS;
            genCode_q   <= '0;
            xferCount_q <= '0;
        end else begin
            state_q     <= state_d;
            genCode_q   <= genCode_d;
            xferCount_q <= xferCount_d;
        end
    end

endmodule
